// File: rtl/bin2bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Ceiling log2, used to size the shift counter at elaboration time.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit adjust: add 3 to any digit above 4 before the shift.
module bcd_add3_cell
  import bin2bcd_seq_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  assign dout = (din > DIGIT_W'(4)) ? din + DIGIT_W'(3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Multi-cycle binary-to-BCD converter, one magnitude bit per clock, with
// start/ready/valid handshake, optional signed input, overflow and blanking mask.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned W      = 20,
  parameter int unsigned D      = 7,
  parameter int unsigned SIGNED = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [W-1:0]         bin,
  output logic                 ready,
  output logic                 valid,
  output logic [DIGIT_W*D-1:0] bcd,
  output logic                 neg,
  output logic                 ovf,
  output logic [D-1:0]         lz_mask
);

  localparam int unsigned BW    = DIGIT_W * D;
  localparam int unsigned CNT_W = clog2(W + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]       mag_q, mag_d;
  logic [BW-1:0]      dig_q, dig_d;
  logic               sign_q, sign_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic               ready_q, ready_d;
  logic               valid_q, valid_d;
  logic [BW-1:0]      bcd_q, bcd_d;
  logic               neg_q, neg_d;
  logic               ovf_q, ovf_d;
  logic [D-1:0]       lz_q, lz_d;

  logic [BW-1:0]      adj;
  logic [BW-1:0]      dig_sh;
  logic [D-1:0]       lz_sh;
  logic               in_neg;

  // All digits are adjusted in parallel ahead of the shift.
  for (genvar i = 0; i < D; i++) begin : g_dig
    bcd_add3_cell u_cell (
      .din  (dig_q[DIGIT_W*i +: DIGIT_W]),
      .dout (adj[DIGIT_W*i +: DIGIT_W])
    );
  end

  assign dig_sh = {adj[BW-2:0], mag_q[W-1]};
  assign in_neg = (SIGNED != 0) && bin[W-1];

  // Leading-zero mask of the post-shift digits; digit 0 is never blanked.
  always_comb begin
    logic allz;
    allz  = 1'b1;
    lz_sh = '0;
    for (int i = int'(D) - 1; i >= 1; i--) begin
      allz     = allz && (dig_sh[DIGIT_W*i +: DIGIT_W] == '0);
      lz_sh[i] = allz;
    end
  end

  // Next-state and datapath.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mag_d     = mag_q;
    dig_d     = dig_q;
    sign_d    = sign_q;
    ovf_acc_d = ovf_acc_q;
    valid_d   = 1'b0;
    bcd_d     = bcd_q;
    neg_d     = neg_q;
    ovf_d     = ovf_q;
    lz_d      = lz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mag_d     = in_neg ? W'(~bin + W'(1)) : bin;
          sign_d    = in_neg;
          dig_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_W'(W);
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        dig_d     = dig_sh;
        mag_d     = {mag_q[W-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | adj[BW-1];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          valid_d = 1'b1;
          bcd_d   = dig_sh;
          neg_d   = sign_q;
          ovf_d   = ovf_acc_q | adj[BW-1];
          lz_d    = lz_sh;
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mag_q     <= '0;
      dig_q     <= '0;
      sign_q    <= 1'b0;
      ovf_acc_q <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      bcd_q     <= '0;
      neg_q     <= 1'b0;
      ovf_q     <= 1'b0;
      lz_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mag_q     <= mag_d;
      dig_q     <= dig_d;
      sign_q    <= sign_d;
      ovf_acc_q <= ovf_acc_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      bcd_q     <= bcd_d;
      neg_q     <= neg_d;
      ovf_q     <= ovf_d;
      lz_q      <= lz_d;
    end
  end

  assign ready   = ready_q;
  assign valid   = valid_q;
  assign bcd     = bcd_q;
  assign neg     = neg_q;
  assign ovf     = ovf_q;
  assign lz_mask = lz_q;

endmodule
